// File: rtl/fifo_uart_tx_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states,
// default baud divisor, parity mode constants and a counter-width helper.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_START  = 3'd2,
    S_DATA   = 3'd3,
    S_PARITY = 3'd4,
    S_STOP   = 3'd5
  } state_t;

  // 50 MHz read clock / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 434;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;

  // Width of a counter holding 0..n-1, never less than one bit
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
// Modulo-CLKS_PER_BIT counter; o_tick marks the last cycle of every bit period.
module baud_tick_gen
  import fifo_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic rd_clk,
  input  logic rd_rst,
  input  logic clear,
  output logic o_tick
);

  localparam int CNT_W = cnt_w(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Count 0..CLKS_PER_BIT-1 and wrap; clear holds the phase at zero
  always_ff @(posedge rd_clk) begin
    if (rd_rst || clear) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign o_tick = (cnt == TERM);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read-side consumer: pops one byte per frame and serialises it as
// start bit, LSB-first data, optional even parity and 1 or 2 stop bits.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int DATASIZE     = 8,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY_EN    = PARITY_NONE,
  parameter int STOP_BITS    = 1
) (
  input  logic                rd_clk,
  input  logic                rd_rst,
  input  logic                i_fifo_empty,
  input  logic [DATASIZE-1:0] i_rd_data,
  output logic                o_rd_en,
  output logic                o_tx,
  output logic                o_busy,
  output logic                o_frame_done
);

  localparam int IDX_W = cnt_w(DATASIZE);
  localparam logic [IDX_W-1:0] LAST_DATA = IDX_W'(DATASIZE - 1);
  localparam logic [IDX_W-1:0] LAST_STOP = IDX_W'(STOP_BITS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [IDX_W-1:0]    bit_idx;
  logic [DATASIZE-1:0] shift_reg;
  logic                parity_bit;
  logic                tx_q;
  logic                tx_nxt;
  logic                tick;
  logic                baud_clear;
  logic                last_stop;

  // Bit timing restarts from phase zero on every entry to START
  assign baud_clear = (state == S_IDLE) || (state == S_FETCH);

  baud_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .rd_clk(rd_clk),
    .rd_rst(rd_rst),
    .clear (baud_clear),
    .o_tick(tick)
  );

  assign last_stop = (state == S_STOP) && tick && (bit_idx == LAST_STOP);

  // State register
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; the STOP exit re-enters FETCH directly when more data waits
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!i_fifo_empty) state_nxt = S_FETCH;
      S_FETCH:  state_nxt = S_START;
      S_START:  if (tick) state_nxt = S_DATA;
      S_DATA:   if (tick && (bit_idx == LAST_DATA))
                  state_nxt = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP:   if (last_stop) state_nxt = i_fifo_empty ? S_IDLE : S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Control outputs; pop and done are masked while reset is asserted
  always_comb begin
    o_rd_en      = !rd_rst && !i_fifo_empty && ((state == S_IDLE) || last_stop);
    o_frame_done = !rd_rst && last_stop;
    o_busy       = (state != S_IDLE);
  end

  // Line level for the cycle after the coming edge, so o_tx is a plain flop
  always_comb begin
    tx_nxt = 1'b1;
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = ((state == S_DATA) && tick) ? shift_reg[1] : shift_reg[0];
      S_PARITY: tx_nxt = parity_bit;
      default:  tx_nxt = 1'b1;
    endcase
  end

  // Bit index and registered serial line
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      bit_idx <= '0;
      tx_q    <= 1'b1;
    end else begin
      tx_q <= tx_nxt;
      case (state)
        S_FETCH: bit_idx <= '0;
        S_DATA:  if (tick) bit_idx <= (bit_idx == LAST_DATA) ? '0 : bit_idx + 1'b1;
        S_STOP:  if (tick) bit_idx <= last_stop ? '0 : bit_idx + 1'b1;
        default: bit_idx <= bit_idx;
      endcase
    end
  end

  // Payload capture and shifting; i_rd_data is looked at only in FETCH
  always_ff @(posedge rd_clk) begin
    if (state == S_FETCH) begin
      shift_reg  <= i_rd_data;
      parity_bit <= ^i_rd_data;
    end else if ((state == S_DATA) && tick) begin
      shift_reg  <= shift_reg >> 1;
    end
  end

  assign o_tx = tx_q;

endmodule
